// File: rtl/rd_burst_arb.sv
`default_nettype none
// ============================================================================
//  Module   : rd_burst_arb
//  Purpose  : Two-requester round-robin burst arbiter on the read side of an
//             asynchronous FIFO. It grants one requester at a time, pops
//             len+1 words through rinc and returns each word on dout with a
//             one-hot dvalid. It pulses done at the end of each burst.
//  Revision : 1.0 - initial release
// ============================================================================
module rd_burst_arb #(
    parameter int DATA_SIZE = 8,
    parameter int LEN_W     = 4
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 rempty,
    input  logic [DATA_SIZE-1:0] rdata,
    output logic                 rinc,
    input  logic [1:0]           req,
    input  logic [LEN_W-1:0]     len0,
    input  logic [LEN_W-1:0]     len1,
    output logic [1:0]           gnt,
    output logic [DATA_SIZE-1:0] dout,
    output logic [1:0]           dvalid,
    output logic [1:0]           done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [LEN_W-1:0] C_CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_owner;      // requester holding the current burst
    logic             r_last;       // requester granted most recently
    logic [LEN_W-1:0] r_len_q;      // burst length minus one, captured at grant
    logic [LEN_W-1:0] r_cnt;        // words popped in the current burst

    logic             w_win;
    logic             w_owner_req;
    logic [1:0]       w_owner_oh;
    logic             w_last_word;

    // On a tie the requester not granted last wins; otherwise the lone requester wins.
    assign w_win       = (req == 2'b11) ? ~r_last : req[1];
    assign w_owner_req = req[r_owner];
    assign w_owner_oh  = r_owner ? 2'b10 : 2'b01;
    // The counter wraps naturally, so a len of all-ones ends on the 2^LEN_W-th word.
    assign w_last_word = rinc & (r_cnt == r_len_q);

    // State register with asynchronous reset.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode. The burst ends on the last word or when the owner lets go.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req != 2'b00) w_state_nxt = S_XFER;
            S_XFER:  if (w_last_word || !w_owner_req) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pop strobe. It is combinational so that an empty FIFO or a withdrawn request stalls at once.
    always_comb begin
        rinc = (r_state == S_XFER) & ~rempty & w_owner_req;
    end

    // Grant, burst bookkeeping, data return and done pulse.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            gnt     <= 2'b00;
            dvalid  <= 2'b00;
            done    <= 2'b00;
            dout    <= '0;
            r_cnt   <= '0;
            r_len_q <= '0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            dvalid <= rinc ? w_owner_oh : 2'b00;
            done   <= 2'b00;
            if (rinc) begin
                dout  <= rdata;
                r_cnt <= r_cnt + C_CNT_ONE;
            end
            case (r_state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        r_owner <= w_win;
                        r_len_q <= w_win ? len1 : len0;
                        r_cnt   <= '0;
                        gnt     <= w_win ? 2'b10 : 2'b01;
                    end
                end
                S_XFER: begin
                    if (w_state_nxt == S_DONE) begin
                        gnt  <= 2'b00;
                        done <= w_owner_oh;
                    end
                end
                S_DONE: begin
                    r_last <= r_owner;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rd_burst_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rd_burst_arb
//  Purpose  : Self-checking bench for rd_burst_arb. A queue models the FIFO,
//             and a burst-level reference model predicts the outputs cycle
//             by cycle. A vector table, directed corner sequences and a
//             randomised run drive the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rd_burst_arb;

    logic       rclk;
    logic       rrst_n;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] gnt;
    logic [7:0] dout;
    logic [1:0] dvalid;
    logic [1:0] done;

    rd_burst_arb #(.DATA_SIZE(8), .LEN_W(4)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .rempty (rempty),
        .rdata  (rdata),
        .rinc   (rinc),
        .req    (req),
        .len0   (len0),
        .len1   (len1),
        .gnt    (gnt),
        .dout   (dout),
        .dvalid (dvalid),
        .done   (done)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int total = 0;
    int bad   = 0;

    // FIFO contents, head at index 0
    logic [7:0] q[$];
    logic [7:0] wctr = 8'h10;

    // Reference model: an owner plus a count of words still owed
    bit         m_busy;     // a burst is in progress
    bit         m_ending;   // the cycle after a burst ends (done shown)
    bit         m_owner;
    bit         m_last;
    int         m_left;
    logic [1:0] e_gnt, e_dvalid, e_done;
    logic [7:0] e_dout;
    bit         e_rinc;

    // Per-run tallies of what the DUT did
    int n_rinc, n_done0, n_done1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void fifo_drive();
        rempty = (q.size() == 0);
        rdata  = (q.size() == 0) ? 8'h00 : q[0];
    endfunction

    function automatic void push_words(input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back(wctr);
            wctr = wctr + 8'h01;
        end
    endfunction

    function automatic void model_reset();
        m_busy   = 0;
        m_ending = 0;
        m_owner  = 0;
        m_last   = 1;
        m_left   = 0;
        e_gnt    = 2'b00;
        e_dvalid = 2'b00;
        e_done   = 2'b00;
        e_dout   = 8'h00;
    endfunction

    task automatic do_reset();
        rrst_n = 1'b0;
        req    = 2'b00;
        len0   = 4'd0;
        len1   = 4'd0;
        q.delete();
        fifo_drive();
        model_reset();
        @(negedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    // One clock cycle. Inputs are already set at a negedge.
    task automatic step();
        logic [7:0] word;
        logic [1:0] oh;
        fifo_drive();
        #1;
        e_rinc = m_busy && !rempty && req[m_owner];
        chk("rinc", {31'd0, rinc}, {31'd0, e_rinc});
        n_rinc += int'(rinc);
        word = rdata;
        @(posedge rclk);
        oh       = m_owner ? 2'b10 : 2'b01;
        e_dvalid = 2'b00;
        e_done   = 2'b00;
        if (m_busy) begin
            if (e_rinc) begin
                m_left--;
                e_dvalid = oh;
                e_dout   = word;
            end
            if ((e_rinc && m_left == 0) || !req[m_owner]) begin
                m_busy   = 0;
                m_ending = 1;
                e_done   = oh;
                e_gnt    = 2'b00;
            end
        end else if (m_ending) begin
            m_ending = 0;
            m_last   = m_owner;
        end else if (req != 2'b00) begin
            m_owner = (req == 2'b11) ? !m_last : req[1];
            m_left  = (m_owner ? int'(len1) : int'(len0)) + 1;
            m_busy  = 1;
            e_gnt   = m_owner ? 2'b10 : 2'b01;
        end
        #1;
        if (e_rinc) void'(q.pop_front());
        fifo_drive();
        @(negedge rclk);
        chk("gnt", {30'd0, gnt}, {30'd0, e_gnt});
        chk("dvalid", {30'd0, dvalid}, {30'd0, e_dvalid});
        chk("done", {30'd0, done}, {30'd0, e_done});
        if (e_dvalid != 2'b00) chk("dout", {24'd0, dout}, {24'd0, e_dout});
        n_done0 += int'(done[0]);
        n_done1 += int'(done[1]);
    endtask

    function automatic void clear_tallies();
        n_rinc  = 0;
        n_done0 = 0;
        n_done1 = 0;
    endfunction

    typedef struct {
        logic [1:0] req;
        logic [3:0] len0;
        logic [3:0] len1;
        int         words;
        int         steps;
        int         exp_rinc;
        int         exp_done0;
        int         exp_done1;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2'b01, 4'd3,  4'd0, 4,  12, 4,  1, 0};  // 4-word burst
        vecs[1] = '{2'b11, 4'd0,  4'd0, 20, 12, 4,  2, 2};  // alternating single words
        vecs[2] = '{2'b01, 4'd15, 4'd0, 16, 24, 16, 1, 0};  // 16-word wrap
        vecs[3] = '{2'b10, 4'd0,  4'd2, 8,  10, 6,  0, 2};  // back-to-back bursts
        vecs[4] = '{2'b11, 4'd1,  4'd2, 10, 14, 7,  2, 1};  // mixed lengths
        vecs[5] = '{2'b01, 4'd0,  4'd0, 0,  6,  0,  0, 0};  // empty FIFO stall
        vecs[6] = '{2'b00, 4'd5,  4'd5, 5,  5,  0,  0, 0};  // no requests

        rrst_n = 1'b0;
        do_reset();
        #1;
        chk("reset_gnt", {30'd0, gnt}, 32'd0);
        chk("reset_dvalid", {30'd0, dvalid}, 32'd0);
        chk("reset_done", {30'd0, done}, 32'd0);
        chk("reset_dout", {24'd0, dout}, 32'd0);
        chk("reset_rinc", {31'd0, rinc}, 32'd0);
        @(negedge rclk);

        // Table-driven bursts
        foreach (vecs[i]) begin
            do_reset();
            req  = vecs[i].req;
            len0 = vecs[i].len0;
            len1 = vecs[i].len1;
            push_words(vecs[i].words);
            clear_tallies();
            repeat (vecs[i].steps) step();
            chk($sformatf("vec%0d_rinc_count", i), n_rinc, vecs[i].exp_rinc);
            chk($sformatf("vec%0d_done0", i), n_done0, vecs[i].exp_done0);
            chk($sformatf("vec%0d_done1", i), n_done1, vecs[i].exp_done1);
        end

        // A 6-word burst that starves after 2 words, then resumes
        do_reset();
        req  = 2'b10;
        len1 = 4'd5;
        push_words(2);
        clear_tallies();
        repeat (10) step();
        chk("stall_rinc_count", n_rinc, 2);
        chk("stall_gnt", {30'd0, gnt}, 32'd2);
        chk("stall_rinc", {31'd0, rinc}, 32'd0);
        push_words(4);
        repeat (8) step();
        chk("stall_total_rinc", n_rinc, 6);
        chk("stall_done1", n_done1, 1);

        // The owner abandons a 16-word burst after 3 words
        do_reset();
        req  = 2'b01;
        len0 = 4'd15;
        push_words(10);
        clear_tallies();
        repeat (4) step();
        req = 2'b00;
        repeat (4) step();
        chk("abandon_rinc_count", n_rinc, 3);
        chk("abandon_done0", n_done0, 1);
        chk("abandon_fifo_left", q.size(), 7);

        // Reset mid-burst, then a tie goes to requester 0
        do_reset();
        req  = 2'b01;
        len0 = 4'd7;
        push_words(10);
        clear_tallies();
        repeat (3) step();
        chk("midrst_rinc_count", n_rinc, 2);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("midrst_rinc", {31'd0, rinc}, 32'd0);
        chk("midrst_gnt", {30'd0, gnt}, 32'd0);
        chk("midrst_dvalid", {30'd0, dvalid}, 32'd0);
        chk("midrst_done", {30'd0, done}, 32'd0);
        q.delete();
        fifo_drive();
        model_reset();
        @(negedge rclk);
        rrst_n = 1'b1;
        req    = 2'b11;
        len0   = 4'd0;
        len1   = 4'd0;
        push_words(4);
        step();
        chk("midrst_first_gnt", {30'd0, gnt}, 32'd1);

        // Random traffic against the reference model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                req  = 2'($urandom_range(0, 3));
                len0 = 4'($urandom_range(0, 15));
                len1 = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 1) == 1 && q.size() < 24) begin
                q.push_back(8'($urandom));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
